// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the register file, ALU, PC and memory handshake.
// Optional memory-acknowledge watchdog enabled by defining CTRL_MEM_TIMEOUT_EN.
module ctrl_sequencer #(
    parameter int DATA_W      = 32,
    parameter int OPC_W       = 6,
    parameter int REG_AW      = 5,
    parameter int IMM_W       = 16,
    parameter int SIGN_EXT    = 0,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic              o_addr_sel,
    output logic              o_addr_we,
    output logic              o_data_oe,
    output logic [OPC_W-1:0]  o_opcode,
    output logic [REG_AW-1:0] o_reg_raddr_a,
    output logic [REG_AW-1:0] o_reg_raddr_b,
    output logic [REG_AW-1:0] o_reg_waddr,
    output logic              o_reg_we,
    output logic [DATA_W-1:0] o_literal,
    output logic              o_alu_en,
    output logic              o_pc_inc,
    output logic [DATA_W-1:0] o_ir,
    output logic              o_halted,
    output logic              o_fault
);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, PCINC, HALT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_mem_req;
    logic              r_mem_we;
    logic              r_addr_sel;
    logic              r_data_oe;
    logic [DATA_W-1:0] r_ir;
    logic [OPC_W-1:0]  r_opcode;
    logic [REG_AW-1:0] r_raddr_a;
    logic [REG_AW-1:0] r_raddr_b;
    logic [REG_AW-1:0] r_waddr;
    logic [DATA_W-1:0] r_literal;

    logic              w_ack;
    logic              w_timeout;
    logic [OPC_W-1:0]  w_dec_opc;
    logic [1:0]        w_dec_cls;
    logic              w_dec_halt;
    logic              w_dec_nop;
    logic [IMM_W-1:0]  w_imm;
    logic [DATA_W-1:0] w_literal;
    logic              w_exec_mem;

    // An ack only counts while our own request is actually on the bus.
    assign w_ack      = r_mem_req && i_mem_ack;

    assign w_dec_opc  = r_ir[DATA_W-1 -: OPC_W];
    assign w_dec_cls  = w_dec_opc[OPC_W-1 -: 2];
    assign w_dec_halt = (w_dec_cls == 2'b00) && (&w_dec_opc[OPC_W-3:0]);
    assign w_dec_nop  = (w_dec_cls == 2'b00) && !w_dec_halt;
    assign w_imm      = r_ir[IMM_W-1:0];
    assign w_literal  = (SIGN_EXT != 0) ? {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm}
                                        : {{(DATA_W-IMM_W){1'b0}}, w_imm};
    assign w_exec_mem = (r_opcode[OPC_W-1 -: 2] == 2'b01);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            FETCH: begin
                if (w_timeout) begin
                    w_next = HALT;
                end else if (w_ack) begin
                    w_next = DECODE;
                end
            end
            DECODE: begin
                if (w_dec_halt) begin
                    w_next = HALT;
                end else if (w_dec_nop) begin
                    w_next = PCINC;
                end else begin
                    w_next = EXEC;
                end
            end
            EXEC:    w_next = w_exec_mem ? MEM : WB;
            MEM: begin
                if (w_timeout) begin
                    w_next = HALT;
                end else if (w_ack) begin
                    w_next = r_opcode[0] ? PCINC : WB;
                end
            end
            WB:      w_next = PCINC;
            PCINC:   w_next = FETCH;
            HALT:    w_next = HALT;
            default: w_next = FETCH;
        endcase
    end

    always_comb begin
        o_alu_en  = 1'b0;
        o_addr_we = 1'b0;
        o_reg_we  = 1'b0;
        o_pc_inc  = 1'b0;
        o_halted  = 1'b0;
        unique case (r_state)
            EXEC: begin
                o_alu_en  = 1'b1;
                o_addr_we = w_exec_mem;
            end
            WB:      o_reg_we = 1'b1;
            PCINC:   o_pc_inc = 1'b1;
            HALT:    o_halted = 1'b1;
            default: ;
        endcase
    end

    // Bus controls are registered from the next state so the first request after reset
    // appears one edge late and every drop happens cleanly on the edge after an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_addr_sel <= 1'b0;
            r_data_oe  <= 1'b0;
        end else begin
            r_mem_req  <= (w_next == FETCH) || (w_next == MEM);
            r_addr_sel <= (w_next == MEM);
            r_mem_we   <= (w_next == MEM) && r_opcode[0];
            r_data_oe  <= (w_next == MEM) && r_opcode[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir      <= '0;
            r_opcode  <= '0;
            r_raddr_a <= '0;
            r_raddr_b <= '0;
            r_waddr   <= '0;
            r_literal <= '0;
        end else begin
            if ((r_state == FETCH) && w_ack) begin
                r_ir <= i_mem_rdata;
            end
            if (r_state == DECODE) begin
                r_opcode  <= w_dec_opc;
                r_waddr   <= r_ir[DATA_W-OPC_W-1 -: REG_AW];
                r_raddr_b <= r_ir[DATA_W-OPC_W-1 -: REG_AW];
                r_raddr_a <= r_ir[DATA_W-OPC_W-REG_AW-1 -: REG_AW];
                r_literal <= w_literal;
            end
        end
    end

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_fault;

    // The request drops between every FETCH/MEM visit, so clearing while idle restarts the count on entry.
    assign w_timeout = r_mem_req && !i_mem_ack && (r_tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_fault   <= 1'b0;
        end else begin
            if (r_mem_req && !i_mem_ack) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign o_fault = r_fault;
`else
    assign w_timeout = 1'b0;
    assign o_fault   = 1'b0;
`endif

    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_addr_sel    = r_addr_sel;
    assign o_data_oe     = r_data_oe;
    assign o_opcode      = r_opcode;
    assign o_reg_raddr_a = r_raddr_a;
    assign o_reg_raddr_b = r_raddr_b;
    assign o_reg_waddr   = r_waddr;
    assign o_literal     = r_literal;
    assign o_ir          = r_ir;

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Parametrised multi-cycle instruction sequencer for the microprocessor core.
- Fetches an instruction word through the memory-controller request/acknowledge handshake and decodes it into opcode, register and literal fields.
- Sequences ALU, load and store operations, then drives register-file write enable, address-register load, data-bus drive and PC increment.
- Sits between the memory controller, register file, ALU and PC register.

Parameters:
DATA_W, 32, instruction and data word width
OPC_W, 6, opcode field width (IR[DATA_W-1 -: OPC_W])
REG_AW, 5, register address width; rd = next REG_AW bits below opcode, ra = next REG_AW below rd
IMM_W, 16, literal field width (IR[IMM_W-1:0]); IMM_W <= DATA_W-OPC_W-2*REG_AW
SIGN_EXT, 0, 1 = literal sign-extended to DATA_W, 0 = zero-extended
MEM_TIMEOUT, 255, cycles to wait for mem_ack (optional feature)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
mem_rdata  in  DATA_W  read data from memory controller
mem_ack  in  1  one-cycle completion pulse from memory controller
mem_req  out  1  memory request, level, held until ack
mem_we  out  1  1 = write (store), 0 = read; valid while mem_req
addr_sel  out  1  0 = PC drives address bus, 1 = address register
addr_we  out  1  one-cycle load of address register from ALU result
data_oe  out  1  register-file read port B drives data bus (store)
opcode  out  OPC_W  latched opcode
reg_raddr_a  out  REG_AW  register-file read port A address (ra)
reg_raddr_b  out  REG_AW  register-file read port B address (rd, for store)
reg_waddr  out  REG_AW  register-file write address (rd)
reg_we  out  1  one-cycle register write strobe
literal  out  DATA_W  extended literal
alu_en  out  1  one-cycle ALU evaluate strobe
pc_inc  out  1  one-cycle PC increment strobe
ir  out  DATA_W  instruction register
halted  out  1  HALT reached
fault  out  1  memory timeout (optional feature)

Behaviour:
- Reset, asynchronous: state=FETCH and every output 0 (ir=0, literal=0, addresses=0, all strobes 0, halted=0, fault=0). The first request is issued the first clk edge after reset deasserts. Reset mid-transaction drops mem_req immediately; the memory controller must tolerate an abandoned request.
- Instruction class = opcode[OPC_W-1:OPC_W-2]:
  - 01: memory op; opcode[0]=1 store, 0 load.
  - 10: ALU reg-reg.
  - 11: ALU reg-imm.
  - 00: NOP, except opcode all-ones-low (00 followed by 1s), which is HALT.
- FETCH: mem_req=1, mem_we=0, addr_sel=0. On mem_ack: ir<=mem_rdata, mem_req<=0, go to DECODE.
- DECODE (1 cycle): latch opcode, reg_waddr=rd, reg_raddr_b=rd, reg_raddr_a=ra, and literal (extended per SIGN_EXT). Next state:
  - NOP: PCINC.
  - HALT: HALT.
  - Otherwise: EXEC.
- EXEC (1 cycle): alu_en=1. ALU classes go to WB. Memory class asserts addr_we=1 (address = ra + literal) and goes to MEM.
- MEM: mem_req=1, addr_sel=1, mem_we=opcode[0], data_oe=opcode[0]. Hold until mem_ack.
  - Load: on ack, go to WB.
  - Store: on ack, go to PCINC. mem_req, mem_we and data_oe drop on the cycle after ack.
- WB (1 cycle): reg_we=1. The register file captures mem_rdata for a load or the ALU result for an ALU op; the datapath mux is driven by opcode. Go to PCINC.
- PCINC (1 cycle): pc_inc=1, go to FETCH.
- HALT: halted=1, all strobes 0, stays until reset.
- mem_ack while not in FETCH or MEM is ignored. mem_ack on the same edge mem_req first rises is legal; zero-wait completion is accepted.
- Cycle counts from mem_ack in FETCH to the next FETCH mem_req:
  - ALU op: 4 (DECODE, EXEC, WB, PCINC).
  - NOP: 2.
  - Load: 3 + memory wait + 2.
  - Store: 3 + memory wait + 1.
- Strobes alu_en, addr_we, reg_we and pc_inc are never high more than one cycle per instruction.

Optional Feature:
- Macro: CTRL_MEM_TIMEOUT_EN.
- With the macro defined: a counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 without mem_ack. When it reaches MEM_TIMEOUT, mem_req drops and fault=1 is set and latched, and state goes to HALT (halted=1). A mem_ack arriving in the same cycle the counter reaches MEM_TIMEOUT wins, and no fault is raised.
- Without the macro: no counter; waits indefinitely; fault is tied 0.

Test Plan:
1. Reset, then fetch ir=0x8422_0000 (class 10, rd=1, ra=2), ack after 3 cycles -> alu_en one cycle after DECODE, reg_we with reg_waddr=1, pc_inc, next mem_req 4 cycles after ack.
2. Load 0x4062_FFFC with SIGN_EXT=1 -> literal=0xFFFF_FFFC, addr_we pulse, MEM with mem_we=0 addr_sel=1, reg_we with reg_waddr=3 after the data ack.
3. Store opcode 0x11 (ir=0x4462_0010) -> reg_raddr_b=3, mem_we=1 and data_oe=1 until ack, no reg_we, pc_inc the cycle after ack.
4. HALT opcode 0x0F -> halted=1, no further mem_req over 50 cycles; reset clears halted and refetches.
5. Assert reset mid-MEM (mem_req=1) -> mem_req=0 asynchronously, all outputs 0, FETCH restarts.
6. With CTRL_MEM_TIMEOUT_EN and MEM_TIMEOUT=8, withhold ack -> fault=1 and halted=1 after 8 cycles; a second run with ack on cycle 8 -> no fault.
